// File: rtl/rps_match_controller.sv
// Rock-paper-scissors match controller: collects two moves per round, strobes the scorer,
// keeps score and declares a winner. Define RPS_MATCH_TIMEOUT_EN to enable forfeit-on-timeout.
module rps_match_controller #(
  parameter int unsigned ROUNDS         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] p1_move,
  input  logic       p1_valid,
  output logic       p1_ready,
  input  logic [1:0] p2_move,
  input  logic       p2_valid,
  output logic       p2_ready,
  output logic [1:0] player1_input,
  output logic [1:0] player2_input,
  output logic       play,
  output logic [7:0] round_count,
  output logic [7:0] p1_wins,
  output logic [7:0] p2_wins,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       invalid_err
);

  localparam logic [1:0] MvRock     = 2'b01;
  localparam logic [1:0] MvPaper    = 2'b10;
  localparam logic [1:0] MvScissors = 2'b11;
  localparam logic [7:0] RoundsW    = 8'(ROUNDS);
  localparam logic [7:0] HalfW      = 8'(ROUNDS / 2);

  if (ROUNDS < 1 || ROUNDS > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
  begin : g_param_check
    $error("rps_match_controller: parameter out of range");
  end

  typedef enum logic [2:0] {StIdle, StCollect, StPlay, StResult, StDone} state_e;

  state_e state;
  logic   p1_have, p2_have;
`ifdef RPS_MATCH_TIMEOUT_EN
  logic [15:0] timer;
`endif

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == MvRock && b == MvScissors) || (a == MvScissors && b == MvPaper) ||
           (a == MvPaper && b == MvRock);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  logic p1_xfer, p2_xfer, p1_take, p2_take, p1_next, p2_next;

  assign p1_ready = (state == StCollect) && !p1_have;
  assign p2_ready = (state == StCollect) && !p2_have;
  assign p1_xfer  = p1_valid && p1_ready;
  assign p2_xfer  = p2_valid && p2_ready;
  assign p1_take  = p1_xfer && (p1_move != 2'b00);
  assign p2_take  = p2_xfer && (p2_move != 2'b00);
  assign p1_next  = p1_have || p1_take;
  assign p2_next  = p2_have || p2_take;

  assign busy = (state == StCollect) || (state == StPlay) || (state == StResult);
  assign done = (state == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      p1_have       <= 1'b0;
      p2_have       <= 1'b0;
      player1_input <= 2'b00;
      player2_input <= 2'b00;
      play          <= 1'b0;
      round_count   <= 8'd0;
      p1_wins       <= 8'd0;
      p2_wins       <= 8'd0;
      winner        <= 2'b00;
      invalid_err   <= 1'b0;
`ifdef RPS_MATCH_TIMEOUT_EN
      timer         <= 16'd0;
`endif
    end else begin
      play        <= 1'b0;
      invalid_err <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state       <= StCollect;
            round_count <= 8'd0;
            p1_wins     <= 8'd0;
            p2_wins     <= 8'd0;
            winner      <= 2'b00;
`ifdef RPS_MATCH_TIMEOUT_EN
            timer       <= 16'd0;
`endif
          end
        end
        StCollect: begin
          // An INVALID move is consumed but not latched, so ready stays high.
          invalid_err <= (p1_xfer && !p1_take) || (p2_xfer && !p2_take);
          if (p1_take) begin
            player1_input <= p1_move;
            p1_have       <= 1'b1;
          end
          if (p2_take) begin
            player2_input <= p2_move;
            p2_have       <= 1'b1;
          end
          if (p1_next && p2_next) begin
            state <= StPlay;
            play  <= 1'b1;
          end
`ifdef RPS_MATCH_TIMEOUT_EN
          else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
            timer <= 16'd0;
            // Forfeit: the only player who moved takes the round, scorer is bypassed.
            if (p1_next ^ p2_next) begin
              state       <= StResult;
              round_count <= sat_inc(round_count);
              if (p1_next) p1_wins <= sat_inc(p1_wins);
              else         p2_wins <= sat_inc(p2_wins);
            end
          end else begin
            timer <= timer + 16'd1;
          end
`endif
        end
        StPlay: begin
          state       <= StResult;
          round_count <= sat_inc(round_count);
          if (beats(player1_input, player2_input))      p1_wins <= sat_inc(p1_wins);
          else if (beats(player2_input, player1_input)) p2_wins <= sat_inc(p2_wins);
        end
        StResult: begin
          p1_have       <= 1'b0;
          p2_have       <= 1'b0;
          player1_input <= 2'b00;
          player2_input <= 2'b00;
          if (round_count == RoundsW || p1_wins > HalfW || p2_wins > HalfW) begin
            state <= StDone;
            if (p1_wins > p2_wins)      winner <= 2'b01;
            else if (p2_wins > p1_wins) winner <= 2'b10;
            else                        winner <= 2'b00;
          end else begin
            state <= StCollect;
`ifdef RPS_MATCH_TIMEOUT_EN
            timer <= 16'd0;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
